// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that merges several byte-stream requesters into one SPI TX FIFO push port.
// An owner keeps the port until its packet ends, its burst budget runs out or it stalls too long.
module spi_tx_arbiter #(
    parameter int NumReq      = 2,
    parameter int MaxBurst    = 16,
    parameter int IdleTimeout = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*8-1:0]   req_data_i,
    input  logic [NumReq-1:0]     req_last_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic [NumReq-1:0]     grant_o,
    output logic                  trunc_o,
    output logic                  timeout_o
);

    localparam int IdxW = $clog2(NumReq);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e                 state_q;
    logic [IdxW-1:0]        owner_q;
    logic [IdxW-1:0]        rr_ptr_q;
    logic [NumReq-1:0]      grant_q;
    logic [7:0]             byte_cnt_q;
    logic [9:0]             stall_cnt_q;
    logic                   trunc_q;
    logic                   timeout_q;

    logic                   locked;
    logic                   owner_valid;
    logic                   owner_last;
    logic                   xfer;
    logic                   burst_hit;
    logic                   stall_hit;
    logic                   release_last;
    logic                   release_trunc;
    logic                   release_timeout;
    logic                   release_any;
    logic [IdxW-1:0]        next_owner;

    // First valid requester found searching upward from ptr+1, wrapping around.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] valid,
                                                input logic [IdxW-1:0]   ptr);
        logic [IdxW-1:0] pick;
        logic            found;
        int              cand;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= NumReq; i++) begin
            cand = (int'(ptr) + i) % NumReq;
            if (!found && valid[cand]) begin
                pick  = IdxW'(cand);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign locked      = (state_q == LOCKED);
    assign owner_valid = req_valid_i[owner_q];
    assign owner_last  = req_last_i[owner_q];
    assign xfer        = locked & owner_valid & tx_ready_i;
    assign next_owner  = rr_pick(req_valid_i, rr_ptr_q);

    assign burst_hit = ({1'b0, byte_cnt_q} + 9'd1) == 9'(MaxBurst);
    assign stall_hit = ({1'b0, stall_cnt_q} + 11'd1) == 11'(IdleTimeout);

    // A last byte that also exhausts the burst budget is an ordinary release.
    assign release_last    = xfer & owner_last;
    assign release_trunc   = xfer & ~owner_last & burst_hit;
    assign release_timeout = locked & ~owner_valid & stall_hit;
    assign release_any     = release_last | release_trunc | release_timeout;

    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'd0;
        req_ready_o = '0;
        if (locked) begin
            tx_valid_o           = owner_valid;
            tx_data_o            = req_data_i[{owner_q, 3'b000} +: 8];
            req_ready_o[owner_q] = tx_ready_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= IdxW'(NumReq - 1);
            grant_q     <= '0;
            byte_cnt_q  <= 8'd0;
            stall_cnt_q <= 10'd0;
            trunc_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            trunc_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        state_q     <= LOCKED;
                        owner_q     <= next_owner;
                        grant_q     <= {{(NumReq-1){1'b0}}, 1'b1} << next_owner;
                        byte_cnt_q  <= 8'd0;
                        stall_cnt_q <= 10'd0;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        byte_cnt_q <= byte_cnt_q + 8'd1;
                    end
                    // Backpressure (valid high, ready low) is not a stall.
                    if (owner_valid) begin
                        stall_cnt_q <= 10'd0;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + 10'd1;
                    end
                    if (release_any) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        rr_ptr_q  <= owner_q;
                        trunc_q   <= release_trunc;
                        timeout_q <= release_timeout;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign trunc_o   = trunc_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: a cycle-level reference of the arbitration rules checked every cycle,
// plus directed packet scenarios with literal byte/grant/pulse expectations.
module tb_spi_tx_arbiter;

    localparam int NumReq      = 2;
    localparam int MaxBurst    = 4;
    localparam int IdleTimeout = 8;

    logic                clk;
    logic                rst_ni;
    logic [NumReq-1:0]   req_valid;
    logic [NumReq*8-1:0] req_data;
    logic [NumReq-1:0]   req_last;
    logic [NumReq-1:0]   req_ready;
    logic                tx_valid;
    logic [7:0]          tx_data;
    logic                tx_ready;
    logic [NumReq-1:0]   grant;
    logic                trunc;
    logic                timeout;

    spi_tx_arbiter #(
        .NumReq      (NumReq),
        .MaxBurst    (MaxBurst),
        .IdleTimeout (IdleTimeout)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .trunc_o     (trunc),
        .timeout_o   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Requester byte queues: {last, data}
    logic [8:0] rq [NumReq][$];
    logic [NumReq-1:0] acc;

    // Reference model state and observation logs
    int          m_own   = -1;
    int          m_rr    = NumReq - 1;
    int          m_bytes = 0;
    int          m_stall = 0;
    bit          m_tp    = 0;
    bit          m_op    = 0;
    int          cyc     = 0;
    logic [7:0]  xlog_d[$];
    int          xlog_c[$];
    logic [1:0]  glog[$];
    logic [1:0]  prev_eg = '0;
    int          trunc_cnt = 0;
    int          to_cnt    = 0;
    int          to_cyc    = 0;

    logic [1:0]  eg;
    logic [1:0]  er;
    logic        ev;
    logic [7:0]  ed;
    bit          xf;
    bit          rel;
    bit          found;

    always @(negedge clk) begin
        cyc++;
        if (!rst_ni) begin
            m_own = -1; m_rr = NumReq - 1; m_bytes = 0; m_stall = 0; m_tp = 0; m_op = 0;
        end
        eg = '0; er = '0; ev = 1'b0; ed = 8'd0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            er[m_own] = tx_ready;
            ev        = req_valid[m_own];
            ed        = req_data[8*m_own +: 8];
        end
        chk("grant", grant, eg);
        chk("req_ready", req_ready, er);
        chk("tx_valid", tx_valid, ev);
        chk("tx_data", tx_data, ed);
        chk("trunc", trunc, m_tp);
        chk("timeout", timeout, m_op);
        if (eg != 0 && eg != prev_eg) glog.push_back(eg);
        prev_eg = eg;
        if (m_tp) trunc_cnt++;
        if (m_op) begin to_cnt++; to_cyc = cyc; end

        if (rst_ni) begin
            m_tp = 0; m_op = 0;
            if (m_own < 0) begin
                found = 0;
                for (int i = 1; i <= NumReq; i++) begin
                    if (!found && req_valid[(m_rr + i) % NumReq]) begin
                        m_own = (m_rr + i) % NumReq;
                        found = 1;
                    end
                end
                m_bytes = 0; m_stall = 0;
            end else begin
                xf  = req_valid[m_own] && tx_ready;
                rel = 0;
                if (xf) begin
                    m_bytes++;
                    xlog_d.push_back(req_data[8*m_own +: 8]);
                    xlog_c.push_back(cyc);
                    if (req_last[m_own]) rel = 1;
                    else if (m_bytes == MaxBurst) begin rel = 1; m_tp = 1; end
                end
                if (req_valid[m_own]) m_stall = 0;
                else begin
                    m_stall++;
                    if (m_stall == IdleTimeout) begin rel = 1; m_op = 1; end
                end
                if (rel) begin m_rr = m_own; m_own = -1; end
            end
        end
    end

    task automatic drive();
        for (int k = 0; k < NumReq; k++) begin
            if (rq[k].size() > 0) begin
                req_valid[k]      = 1'b1;
                req_data[8*k +: 8] = rq[k][0][7:0];
                req_last[k]       = rq[k][0][8];
            end else begin
                req_valid[k]      = 1'b0;
                req_data[8*k +: 8] = 8'd0;
                req_last[k]       = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < NumReq; k++) begin
            if (acc[k]) void'(rq[k].pop_front());
        end
        drive();
    endtask

    task automatic clear_logs();
        xlog_d.delete();
        xlog_c.delete();
        glog.delete();
        trunc_cnt = 0;
        to_cnt    = 0;
    endtask

    task automatic chk_seq(input string name, input int n, input logic [63:0] e);
        logic [31:0] act;
        chk({name, "_len"}, xlog_d.size(), n);
        for (int i = 0; i < n; i++) begin
            act = (i < xlog_d.size()) ? {24'd0, xlog_d[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s[%0d]", name, i), act, {24'd0, e[8*(n-1-i) +: 8]});
        end
    endtask

    initial begin
        rst_ni    = 1'b0;
        tx_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (3) step();
        rst_ni = 1'b1;
        step();
        chk("idle_grant", grant, 2'b00);
        chk("idle_tx_valid", tx_valid, 1'b0);

        // Simultaneous start: both requesters, 3-byte packets
        clear_logs();
        rq[0].push_back(9'h0A0); rq[0].push_back(9'h0A1); rq[0].push_back(9'h1A2);
        rq[1].push_back(9'h0B0); rq[1].push_back(9'h0B1); rq[1].push_back(9'h1B2);
        drive();
        repeat (12) step();
        chk_seq("s1_bytes", 6, {8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2});
        chk("s1_gap", xlog_c[3] - xlog_c[2], 2);
        chk("s1_ngrants", glog.size(), 2);
        chk("s1_grant0", glog[0], 2'b01);
        chk("s1_grant1", glog[1], 2'b10);

        // Backpressure for 5 cycles after the first byte
        clear_logs();
        rq[0].push_back(9'h0C0); rq[0].push_back(9'h0C1); rq[0].push_back(9'h1C2);
        drive();
        for (int i = 0; i < 10 && xlog_d.size() < 1; i++) step();
        tx_ready = 1'b0;
        repeat (5) step();
        tx_ready = 1'b1;
        repeat (8) step();
        chk_seq("s2_bytes", 3, {8'hC0, 8'hC1, 8'hC2});
        chk("s2_resume_gap", xlog_c[1] - xlog_c[0], 6);
        chk("s2_timeouts", to_cnt, 0);

        // Truncation: 6-byte packet against MaxBurst=4, requester 1 waiting
        clear_logs();
        for (int i = 0; i < 6; i++) rq[0].push_back({(i == 5), 8'hD0 + 8'(i)});
        drive();
        step();
        step();
        rq[1].push_back(9'h0E0); rq[1].push_back(9'h1E1);
        drive();
        repeat (20) step();
        chk_seq("s3_bytes", 8, {8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hE0, 8'hE1, 8'hD4, 8'hD5});
        chk("s3_truncs", trunc_cnt, 1);
        chk("s3_next_grant", glog[1], 2'b10);

        // Timeout: owner goes silent after 2 bytes
        clear_logs();
        rq[0].push_back(9'h0F0); rq[0].push_back(9'h0F1);
        drive();
        repeat (16) step();
        chk_seq("s4_bytes", 2, {8'hF0, 8'hF1});
        chk("s4_timeouts", to_cnt, 1);
        chk("s4_timeout_lag", to_cyc - xlog_c[1], 9);
        chk("s4_truncs", trunc_cnt, 0);
        chk("s4_grant_end", grant, 2'b00);

        // Last coinciding with the burst limit
        clear_logs();
        for (int i = 0; i < 4; i++) rq[1].push_back({(i == 3), 8'h60 + 8'(i)});
        drive();
        repeat (10) step();
        chk_seq("s5_bytes", 4, {8'h60, 8'h61, 8'h62, 8'h63});
        chk("s5_truncs", trunc_cnt, 0);

        // Reset in the middle of requester 1's packet
        clear_logs();
        rq[1].push_back(9'h070); rq[1].push_back(9'h071); rq[1].push_back(9'h172);
        drive();
        for (int i = 0; i < 10 && xlog_d.size() < 1; i++) step();
        chk("s6_pre_owner", grant, 2'b10);
        rq[0].push_back(9'h180);
        rst_ni = 1'b0;
        drive();
        step();
        rst_ni = 1'b1;
        clear_logs();
        repeat (12) step();
        chk_seq("s6_bytes", 3, {8'h80, 8'h71, 8'h72});
        chk("s6_first_grant", glog[0], 2'b01);
        chk("s6_pulses", trunc_cnt + to_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

endmodule
